// File: rtl/spart_pkg.sv
// Shared SPART definitions: bus register map, receive FSM states and status word layout.
package spart_pkg;

   localparam logic [1:0] IO_XFER   = 2'b00;
   localparam logic [1:0] REG_RD    = 2'b01;
   localparam logic [1:0] LD_DIV_LO = 2'b10;
   localparam logic [1:0] LD_DIV_HI = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Bit positions inside the status word returned on REG_RD.
   localparam int STAT_RDA  = 0;
   localparam int STAT_OVR  = 1;
   localparam int STAT_FERR = 2;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter
// so idle-high lines do not produce a spurious edge out of reset.
module spart_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled 8N1 frame recovery, receive buffer with rda/overrun/framing
// flags, and the bus read mux for the data and status registers.
module spart_rx
   import spart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic       sample_en,
   input  logic       rxd,
   output logic [7:0] rx2bus,
   output logic       rda
);

   localparam int               SC_W    = $clog2(OVERSAMPLE);
   localparam logic [SC_W-1:0]  SC_MID  = SC_W'(OVERSAMPLE/2 - 1);
   localparam logic [SC_W-1:0]  SC_END  = SC_W'(OVERSAMPLE - 1);
   localparam logic [2:0]       BC_LAST = 3'(DATA_BITS - 1);

   rx_state_t            state, state_nxt;
   logic [SC_W-1:0]      sc, sc_nxt;
   logic [2:0]           bc, bc_nxt;
   logic [DATA_BITS-1:0] sh, rx_buf;
   logic                 rxd_s;
   logic                 shift_en, frame_ok, frame_bad;
   logic                 framing_err, overrun;
   logic                 data_rd, stat_rd;
   logic [7:0]           status;

   spart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rxd),
      .q   (rxd_s)
   );

   assign data_rd = iocs & iorw & (ioaddr == IO_XFER);
   assign stat_rd = iocs & iorw & (ioaddr == REG_RD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sc    <= '0;
         bc    <= '0;
      end else begin
         state <= state_nxt;
         sc    <= sc_nxt;
         bc    <= bc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sc_nxt    = sc;
      bc_nxt    = bc;
      shift_en  = 1'b0;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      if (sample_en) begin
         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  sc_nxt    = '0;
                  state_nxt = START;
               end
            end
            START: begin
               // Mid-bit requalification rejects glitches shorter than half a bit.
               if (sc == SC_MID) begin
                  if (rxd_s) begin
                     state_nxt = IDLE;
                  end else begin
                     sc_nxt    = '0;
                     bc_nxt    = '0;
                     state_nxt = DATA;
                  end
               end else begin
                  sc_nxt = sc + 1'b1;
               end
            end
            DATA: begin
               if (sc == SC_END) begin
                  shift_en = 1'b1;
                  sc_nxt   = '0;
                  if (bc == BC_LAST) state_nxt = STOP;
                  else               bc_nxt    = bc + 1'b1;
               end else begin
                  sc_nxt = sc + 1'b1;
               end
            end
            STOP: begin
               if (sc == SC_END) begin
                  frame_ok  = rxd_s;
                  frame_bad = !rxd_s;
                  state_nxt = IDLE;
               end else begin
                  sc_nxt = sc + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh <= '0;
      end else if (shift_en) begin
         sh <= {rxd_s, sh[DATA_BITS-1:1]};
      end
   end

   // Frame completion beats a concurrent data read, and a data read on that edge
   // means the old byte was consumed, so it is not an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_buf      <= '0;
         rda         <= 1'b0;
         overrun     <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         if (frame_ok) rx_buf <= sh;

         if (frame_ok)     rda <= 1'b1;
         else if (data_rd) rda <= 1'b0;

         if (frame_ok && rda && !data_rd) overrun <= 1'b1;
         else if (stat_rd)                overrun <= 1'b0;

         if (frame_bad)    framing_err <= 1'b1;
         else if (stat_rd) framing_err <= 1'b0;
      end
   end

   always_comb begin
      status            = '0;
      status[STAT_RDA]  = rda;
      status[STAT_OVR]  = overrun;
      status[STAT_FERR] = framing_err;
   end

   always_comb begin
      rx2bus = 8'h00;
      if (data_rd)      rx2bus = 8'(rx_buf);
      else if (stat_rd) rx2bus = status;
   end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: a frame-timing model checks rda/rx2bus every cycle,
// plus literal expectations for each scenario.
module tb_spart_rx;

   localparam int OS        = 16;
   localparam int DIV       = 4;
   localparam int BIT_CLK   = OS * DIV;
   localparam int HALF      = OS / 2;
   localparam int FRAME_END = HALF + OS * 9;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       iocs = 1'b0, iorw = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   logic       rxd = 1'b1;
   logic [1:0] se_cnt = 2'd0;
   logic       sample_en;
   logic [7:0] rx2bus;
   logic       rda;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) se_cnt <= se_cnt + 2'd1;
   assign sample_en = (se_cnt == 2'd3);

   spart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
      .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .sample_en(sample_en), .rxd(rxd), .rx2bus(rx2bus), .rda(rda)
   );

   // Model: the line is seen 2 clk late; once a low is seen on a tick, the start bit is
   // checked HALF ticks later and bit n (1..8 data, 9 stop) HALF + n*OS ticks later.
   logic       m_s1, m_s2, m_busy, m_rda, m_ovr, m_fe;
   logic [7:0] m_sh, m_buf;
   int         m_off, o, n;
   logic       m_drd, m_srd, m_stop, m_ok, m_bad;
   logic [7:0] exp_bus;

   assign o      = m_off + 1;
   assign n      = (o - HALF) / OS;
   assign m_drd  = iocs && iorw && ioaddr == 2'b00;
   assign m_srd  = iocs && iorw && ioaddr == 2'b01;
   assign m_stop = sample_en && m_busy && o == FRAME_END;
   assign m_ok   = m_stop && m_s2;
   assign m_bad  = m_stop && !m_s2;
   assign exp_bus = m_drd ? m_buf : m_srd ? {5'b0, m_fe, m_ovr, m_rda} : 8'h00;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 <= 1'b1; m_s2 <= 1'b1; m_busy <= 1'b0; m_off <= 0;
         m_sh <= 8'h00; m_buf <= 8'h00; m_rda <= 1'b0; m_ovr <= 1'b0; m_fe <= 1'b0;
      end else begin
         m_s1 <= rxd;
         m_s2 <= m_s1;
         if (sample_en) begin
            if (!m_busy) begin
               if (!m_s2) begin
                  m_busy <= 1'b1;
                  m_off  <= 0;
               end
            end else begin
               m_off <= o;
               if (o == HALF && m_s2) m_busy <= 1'b0;
               if (o > HALF && (o - HALF) % OS == 0 && n >= 1 && n <= 8) m_sh[3'(n - 1)] <= m_s2;
               if (m_stop) m_busy <= 1'b0;
            end
         end
         if (m_ok) m_buf <= m_sh;
         m_rda <= m_ok ? 1'b1 : (m_drd ? 1'b0 : m_rda);
         m_ovr <= (m_ok && m_rda && !m_drd) ? 1'b1 : (m_srd ? 1'b0 : m_ovr);
         m_fe  <= m_bad ? 1'b1 : (m_srd ? 1'b0 : m_fe);
      end
   end

   always @(negedge clk) begin
      n_tests++;
      if (rda !== m_rda || rx2bus !== exp_bus) begin
         n_fail++;
         $display("FAIL model t=%0t rda=%b want %b rx2bus=%h want %h", $time, rda, m_rda, rx2bus, exp_bus);
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      @(negedge clk);
      d = rx2bus;
      @(posedge clk);
      #1;
      iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      cyc(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         cyc(BIT_CLK);
      end
      rxd = stop;
      cyc(BIT_CLK);
      rxd = 1'b1;
   endtask

   task automatic wait_rda(input string name);
      int k;
      k = 0;
      while (rda !== 1'b1 && k < 2000) begin
         cyc(1);
         k++;
      end
      if (k >= 2000) chk(name, 8'h00, 8'h01);
   endtask

   initial begin : wdog
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   logic [7:0] d;
   logic [7:0] exp6 [3];

   initial begin
      exp6[0] = 8'h00; exp6[1] = 8'hFF; exp6[2] = 8'h80;
      cyc(5);
      chk("reset_rda", {7'b0, rda}, 8'h00);
      rst = 1'b0;
      cyc(BIT_CLK);
      rd(2'b00, d); chk("reset_data", d, 8'h00);
      rd(2'b01, d); chk("reset_status", d, 8'h00);

      // Single clean byte.
      send_frame(8'hA5, 1'b1);
      cyc(20);
      chk("a5_rda", {7'b0, rda}, 8'h01);
      rd(2'b00, d); chk("a5_data", d, 8'hA5);
      chk("a5_rda_clr", {7'b0, rda}, 8'h00);
      rd(2'b01, d); chk("a5_status", d, 8'h00);

      // Glitch of 5 sample periods.
      rxd = 1'b0; cyc(5 * DIV); rxd = 1'b1; cyc(3 * BIT_CLK);
      rd(2'b01, d); chk("glitch_status", d, 8'h00);
      rd(2'b00, d); chk("glitch_buf", d, 8'hA5);

      // Framing error.
      send_frame(8'h3C, 1'b0);
      cyc(3 * BIT_CLK);
      chk("ferr_rda", {7'b0, rda}, 8'h00);
      rd(2'b01, d); chk("ferr_status", d, 8'h04);
      rd(2'b01, d); chk("ferr_status2", d, 8'h00);

      // Overrun.
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      cyc(20);
      rd(2'b01, d); chk("ovr_status", d, 8'h03);
      rd(2'b00, d); chk("ovr_data", d, 8'h22);
      rd(2'b01, d); chk("ovr_status2", d, 8'h00);

      // Data read on the completion edge of the second byte.
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin : hit
            int k;
            k = 0;
            while (!(m_busy && o == FRAME_END && sample_en) && k < 2000) begin
               cyc(1);
               k++;
            end
            if (k >= 2000) chk("hit_timeout", 8'h00, 8'h01);
            else rd(2'b00, d);
         end
      join
      cyc(20);
      rd(2'b01, d); chk("hit_status", d, 8'h01);
      rd(2'b00, d); chk("hit_data", d, 8'h22);

      // Reset during data bit 4 of 8'hFF.
      rxd = 1'b0; cyc(BIT_CLK);
      rxd = 1'b1; cyc(4 * BIT_CLK + BIT_CLK / 2);
      rst = 1'b1; cyc(3);
      chk("rst_rda", {7'b0, rda}, 8'h00);
      rst = 1'b0;
      cyc(BIT_CLK / 2 + 4 * BIT_CLK);
      rd(2'b01, d); chk("rst_status", d, 8'h00);
      rd(2'b00, d); chk("rst_data", d, 8'h00);
      send_frame(8'h5A, 1'b1);
      cyc(20);
      rd(2'b00, d); chk("after_rst_data", d, 8'h5A);

      // Back-to-back frames, each read as soon as rda rises.
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
            send_frame(8'h80, 1'b1);
         end
         begin
            for (int j = 0; j < 3; j++) begin
               wait_rda("b2b_timeout");
               rd(2'b00, d); chk("b2b_data", d, exp6[j]);
            end
         end
      join
      cyc(20);
      rd(2'b01, d); chk("b2b_status", d, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
